// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a multi-cycle ALU: one operation in
// flight, illegal commands answered locally without touching the ALU.
module alu_req_arbiter #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int LAT_STD   = 1,
    parameter int LAT_MUL   = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,

    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_opa,
    input  logic [WIDTH-1:0]     req0_opb,
    input  logic [CMD_WIDTH-1:0] req0_cmd,
    input  logic                 req0_mode,
    input  logic                 req0_cin,

    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_opa,
    input  logic [WIDTH-1:0]     req1_opb,
    input  logic [CMD_WIDTH-1:0] req1_cmd,
    input  logic                 req1_mode,
    input  logic                 req1_cin,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH+1:0]     rsp_res,
    output logic                 rsp_err,
    output logic                 rsp_oflow,
    output logic                 rsp_cout,
    output logic                 rsp_g,
    output logic                 rsp_l,
    output logic                 rsp_e,

    output logic [WIDTH-1:0]     alu_opa,
    output logic [WIDTH-1:0]     alu_opb,
    output logic [CMD_WIDTH-1:0] alu_cmd,
    output logic                 alu_mode,
    output logic                 alu_cin,
    output logic                 alu_ce,
    output logic [1:0]           alu_inp_valid,
    input  logic [WIDTH+1:0]     alu_res,
    input  logic                 alu_err,
    input  logic                 alu_oflow,
    input  logic                 alu_cout,
    input  logic                 alu_g,
    input  logic                 alu_l,
    input  logic                 alu_e,

    output logic                 busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    logic [1:0]           state;
    logic                 prio;
    logic                 hold_id;
    logic                 hold_mul;
    logic [CNT_W-1:0]     lat_cnt;

    logic [WIDTH-1:0]     opa_q;
    logic [WIDTH-1:0]     opb_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 mode_q;
    logic                 cin_q;

    logic [WIDTH+1:0]     res_q;
    logic                 id_q;
    logic                 err_q;
    logic                 oflow_q;
    logic                 cout_q;
    logic                 g_q;
    logic                 l_q;
    logic                 e_q;

    logic                 winner;
    logic                 accept;
    logic [WIDTH-1:0]     sel_opa;
    logic [WIDTH-1:0]     sel_opb;
    logic [CMD_WIDTH-1:0] sel_cmd;
    logic                 sel_mode;
    logic                 sel_cin;
    logic                 sel_illegal;
    logic                 sel_mul;

    // A lone requester wins outright; prio only breaks ties.
    always_comb begin
        winner = 1'b0;
        if (req0_valid && req1_valid)
            winner = prio;
        else if (req1_valid)
            winner = 1'b1;
    end

    assign accept     = !RESET && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !winner;
    assign req1_ready = accept && winner;

    always_comb begin
        sel_opa  = req0_opa;
        sel_opb  = req0_opb;
        sel_cmd  = req0_cmd;
        sel_mode = req0_mode;
        sel_cin  = req0_cin;
        if (winner) begin
            sel_opa  = req1_opa;
            sel_opb  = req1_opb;
            sel_cmd  = req1_cmd;
            sel_mode = req1_mode;
            sel_cin  = req1_cin;
        end
    end

    always_comb begin
        sel_illegal = sel_mode ? (sel_cmd > CMD_WIDTH'(10)) : (sel_cmd > CMD_WIDTH'(13));
        sel_mul     = sel_mode && ((sel_cmd == CMD_WIDTH'(9)) || (sel_cmd == CMD_WIDTH'(10)));
    end

    // The ALU drive registers only load for legal commands, so an illegal
    // command never appears on alu_* and the last driven values persist.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            prio     <= 1'b0;
            hold_id  <= 1'b0;
            hold_mul <= 1'b0;
            lat_cnt  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cmd_q    <= '0;
            mode_q   <= 1'b0;
            cin_q    <= 1'b0;
            res_q    <= '0;
            id_q     <= 1'b0;
            err_q    <= 1'b0;
            oflow_q  <= 1'b0;
            cout_q   <= 1'b0;
            g_q      <= 1'b0;
            l_q      <= 1'b0;
            e_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        prio    <= ~winner;
                        hold_id <= winner;
                        if (sel_illegal) begin
                            res_q   <= '0;
                            id_q    <= winner;
                            err_q   <= 1'b1;
                            oflow_q <= 1'b0;
                            cout_q  <= 1'b0;
                            g_q     <= 1'b0;
                            l_q     <= 1'b0;
                            e_q     <= 1'b0;
                            state   <= RESP;
                        end else begin
                            opa_q    <= sel_opa;
                            opb_q    <= sel_opb;
                            cmd_q    <= sel_cmd;
                            mode_q   <= sel_mode;
                            cin_q    <= sel_cin;
                            hold_mul <= sel_mul;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    lat_cnt <= hold_mul ? CNT_W'(LAT_MUL) : CNT_W'(LAT_STD);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt <= CNT_W'(1)) begin
                        res_q   <= alu_res;
                        id_q    <= hold_id;
                        err_q   <= alu_err;
                        oflow_q <= alu_oflow;
                        cout_q  <= alu_cout;
                        g_q     <= alu_g;
                        l_q     <= alu_l;
                        e_q     <= alu_e;
                        state   <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_opa       = opa_q;
    assign alu_opb       = opb_q;
    assign alu_cmd       = cmd_q;
    assign alu_mode      = mode_q;
    assign alu_cin       = cin_q;
    assign alu_ce        = (state == ISSUE) || (state == WAIT);
    assign alu_inp_valid = 2'b11;

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;
    assign rsp_res   = res_q;
    assign rsp_err   = err_q;
    assign rsp_oflow = oflow_q;
    assign rsp_cout  = cout_q;
    assign rsp_g     = g_q;
    assign rsp_l     = l_q;
    assign rsp_e     = e_q;

    assign busy = (state != IDLE);

endmodule
